// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between fetch (IF) and load/store (LS), one transaction at a time.
// Latency: request accept -> mem_req_valid_o 1 cycle; mem_rsp_valid_i -> *_rsp_valid_o 1 cycle.
// Backpressure: requester ready only in IDLE for the winner; mem_req_ready_i stalls REQ with fields held.
module mem_bus_arbiter #(
  parameter int XLEN          = 64,
  parameter int LS_STREAK_MAX = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid_i,
  input  logic [XLEN-1:0]   if_req_addr_i,
  output logic              if_req_ready_o,
  output logic              if_rsp_valid_o,
  output logic [XLEN-1:0]   if_rsp_data_o,
  output logic              if_rsp_err_o,
  input  logic              ls_req_valid_i,
  input  logic [XLEN-1:0]   ls_req_addr_i,
  input  logic              ls_req_write_i,
  input  logic [XLEN-1:0]   ls_req_wdata_i,
  input  logic [XLEN/8-1:0] ls_req_wmask_i,
  output logic              ls_req_ready_o,
  output logic              ls_rsp_valid_o,
  output logic [XLEN-1:0]   ls_rsp_data_o,
  output logic              ls_rsp_err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_req_addr_o,
  output logic              mem_req_write_o,
  output logic [XLEN-1:0]   mem_req_wdata_o,
  output logic [XLEN/8-1:0] mem_req_wmask_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rsp_data_i
);

  localparam int SW = $clog2(LS_STREAK_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = XLEN / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;        // 1 = LS owns the transaction
  logic [XLEN-1:0] addr_q, addr_d;
  logic            write_q, write_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            if_rsp_valid_q, if_rsp_valid_d;
  logic [XLEN-1:0] if_rsp_data_q, if_rsp_data_d;
  logic            if_rsp_err_q, if_rsp_err_d;
  logic            ls_rsp_valid_q, ls_rsp_valid_d;
  logic [XLEN-1:0] ls_rsp_data_q, ls_rsp_data_d;
  logic            ls_rsp_err_q, ls_rsp_err_d;
  logic            if_rdy, ls_rdy;
  logic            ls_win, if_win;
  logic            streak_ok;
  logic [TW-1:0]   tmo_inc;
  logic            rsp_fire;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  // LS wins unless IF is also waiting and LS has used up its streak.
  assign streak_ok = (streak_q < SW'(LS_STREAK_MAX));
  assign ls_win    = ls_req_valid_i && (!if_req_valid_i || streak_ok);
  assign if_win    = if_req_valid_i && !ls_win;
  assign tmo_inc   = tmo_q + TW'(1);

  // Next-state, request capture, streak/timeout counters and response generation.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    write_d        = write_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    streak_d       = streak_q;
    tmo_d          = tmo_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    if_rsp_err_d   = if_rsp_err_q;
    ls_rsp_valid_d = 1'b0;
    ls_rsp_data_d  = ls_rsp_data_q;
    ls_rsp_err_d   = ls_rsp_err_q;
    if_rdy         = 1'b0;
    ls_rdy         = 1'b0;
    rsp_fire       = 1'b0;
    rsp_data       = '0;
    rsp_err        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if_rdy = if_win;
        ls_rdy = ls_win;
        if (!if_req_valid_i) streak_d = '0;
        if (ls_win) begin
          owner_d = 1'b1;
          addr_d  = ls_req_addr_i;
          write_d = ls_req_write_i;
          wdata_d = ls_req_wdata_i;
          wmask_d = ls_req_wmask_i;
          state_d = S_REQ;
          // ls_win with IF pending implies streak_ok, so this never overshoots.
          if (if_req_valid_i) streak_d = streak_q + SW'(1);
        end else if (if_win) begin
          owner_d  = 1'b0;
          addr_d   = if_req_addr_i;
          write_d  = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          streak_d = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_inc;
        if (mem_rsp_valid_i) begin
          rsp_fire = 1'b1;
          rsp_data = write_q ? '0 : mem_rsp_data_i;
        end else if (tmo_inc == TW'(TIMEOUT)) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end
        if (rsp_fire) begin
          state_d = S_IDLE;
          if (owner_q) begin
            ls_rsp_valid_d = 1'b1;
            ls_rsp_data_d  = rsp_data;
            ls_rsp_err_d   = rsp_err;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = rsp_data;
            if_rsp_err_d   = rsp_err;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      owner_q        <= 1'b0;
      addr_q         <= '0;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      streak_q       <= '0;
      tmo_q          <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      if_rsp_err_q   <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_data_q  <= '0;
      ls_rsp_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      write_q        <= write_d;
      wdata_q        <= wdata_d;
      wmask_q        <= wmask_d;
      streak_q       <= streak_d;
      tmo_q          <= tmo_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      ls_rsp_data_q  <= ls_rsp_data_d;
      ls_rsp_err_q   <= ls_rsp_err_d;
    end
  end

  // Readies are forced low while reset is asserted so every output reads 0.
  assign if_req_ready_o  = rst & if_rdy;
  assign ls_req_ready_o  = rst & ls_rdy;
  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_addr_o  = addr_q;
  assign mem_req_write_o = write_q;
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_wmask_o = wmask_q;
  assign if_rsp_valid_o  = if_rsp_valid_q;
  assign if_rsp_data_o   = if_rsp_data_q;
  assign if_rsp_err_o    = if_rsp_err_q;
  assign ls_rsp_valid_o  = ls_rsp_valid_q;
  assign ls_rsp_data_o   = ls_rsp_data_q;
  assign ls_rsp_err_o    = ls_rsp_err_q;

endmodule
